// File: rtl/hazard_sequencer_if.sv
// Pipeline <-> hazard sequencer control bundle.
// Latency: n/a (wires only).
// Backpressure: none; the stall outputs are the pipeline's backpressure.
// Inputs to the sequencer: D/E/M/W register specifiers, write enables,
// load indication, branch redirect, data-memory access/ready.
// Outputs from the sequencer: per-register stall/flush, forwarding selects,
// memory timeout pulse.
interface hazard_sequencer_if;
   logic [4:0] Rs1_D;
   logic [4:0] Rs2_D;
   logic [4:0] Rs1_E;
   logic [4:0] Rs2_E;
   logic [4:0] Rd_E;
   logic [4:0] Rd_M;
   logic [4:0] Rd_W;
   logic       RegWrite_M;
   logic       RegWrite_W;
   logic [1:0] ResultSrc_E;
   logic       PCSrc_E;
   logic       MemAccess_M;
   logic       DMemReady;
   logic       StallF;
   logic       StallD;
   logic       StallE;
   logic       StallM;
   logic       FlushD;
   logic       FlushE;
   logic       FlushW;
   logic [1:0] ForwardA_E;
   logic [1:0] ForwardB_E;
   logic       MemTimeout;

   // Pipeline side: drives stage information, consumes controls.
   modport master (
      output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
             RegWrite_M, RegWrite_W, ResultSrc_E, PCSrc_E,
             MemAccess_M, DMemReady,
      input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             ForwardA_E, ForwardB_E, MemTimeout
   );

   // Sequencer side.
   modport slave (
      input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
             RegWrite_M, RegWrite_W, ResultSrc_E, PCSrc_E,
             MemAccess_M, DMemReady,
      output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             ForwardA_E, ForwardB_E, MemTimeout
   );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard/forwarding controller for the 5-stage RV64I pipeline.
// Latency: zero; all controls are combinational from state, counter and inputs.
// Backpressure: freezes F..M while a data-memory access in M is outstanding.
// Ports: clk, rst (async, active-high); hz = slave side of hazard_sequencer_if.
module hazard_sequencer #(
   parameter int INIT_CYCLES = 4,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   hazard_sequencer_if.slave     hz
);

   localparam logic [1:0] S_INIT    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_MEMWAIT = 2'd2;

   localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] MEM_LAST  = CNT_W'(MEM_TIMEOUT - 1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;

   logic [1:0]       w_next_state;
   logic [CNT_W-1:0] w_next_cnt;
   logic             w_lu;
   logic             w_ms;
   logic [1:0]       w_fwd_a;
   logic [1:0]       w_fwd_b;
   logic             w_stall_f, w_stall_d, w_stall_e, w_stall_m;
   logic             w_flush_d, w_flush_e, w_flush_w;
   logic [1:0]       w_forward_a, w_forward_b;
   logic             w_mem_timeout;

   always_comb begin
      w_lu = (hz.ResultSrc_E == 2'b01) && (hz.Rd_E != 5'd0) &&
             ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));
      w_ms = hz.MemAccess_M && !hz.DMemReady;

      // M result is younger than W, so it takes priority; x0 never forwards.
      if (hz.RegWrite_M && (hz.Rd_M != 5'd0) && (hz.Rd_M == hz.Rs1_E))
         w_fwd_a = 2'b10;
      else if (hz.RegWrite_W && (hz.Rd_W != 5'd0) && (hz.Rd_W == hz.Rs1_E))
         w_fwd_a = 2'b01;
      else
         w_fwd_a = 2'b00;

      if (hz.RegWrite_M && (hz.Rd_M != 5'd0) && (hz.Rd_M == hz.Rs2_E))
         w_fwd_b = 2'b10;
      else if (hz.RegWrite_W && (hz.Rd_W != 5'd0) && (hz.Rd_W == hz.Rs2_E))
         w_fwd_b = 2'b01;
      else
         w_fwd_b = 2'b00;
   end

   always_comb begin
      w_next_state  = r_state;
      w_next_cnt    = r_cnt;
      w_stall_f     = 1'b0;
      w_stall_d     = 1'b0;
      w_stall_e     = 1'b0;
      w_stall_m     = 1'b0;
      w_flush_d     = 1'b0;
      w_flush_e     = 1'b0;
      w_flush_w     = 1'b0;
      w_forward_a   = 2'b00;
      w_forward_b   = 2'b00;
      w_mem_timeout = 1'b0;

      case (r_state)
         S_RUN: begin
            w_forward_a = w_fwd_a;
            w_forward_b = w_fwd_b;
            if (w_ms) begin
               // Freeze everything up to M; bubble into W.
               w_stall_f    = 1'b1;
               w_stall_d    = 1'b1;
               w_stall_e    = 1'b1;
               w_stall_m    = 1'b1;
               w_flush_w    = 1'b1;
               w_next_state = S_MEMWAIT;
               w_next_cnt   = CNT_W'(1);
            end else begin
               // A redirect and a load-use bubble may coincide: the PC mux
               // takes the branch target, so the extra D/E bubble is harmless.
               w_stall_f = w_lu;
               w_stall_d = w_lu;
               w_flush_d = hz.PCSrc_E;
               w_flush_e = w_lu || hz.PCSrc_E;
            end
         end

         S_MEMWAIT: begin
            // Outputs ignore DMemReady; completion releases the pipe next
            // cycle, where a held PCSrc_E or load-use is then acted upon.
            w_forward_a = w_fwd_a;
            w_forward_b = w_fwd_b;
            w_stall_f   = 1'b1;
            w_stall_d   = 1'b1;
            w_stall_e   = 1'b1;
            w_stall_m   = 1'b1;
            w_flush_w   = 1'b1;
            if (hz.DMemReady) begin
               w_next_state = S_RUN;
               w_next_cnt   = '0;
            end else if (r_cnt == MEM_LAST) begin
               w_mem_timeout = 1'b1;
               w_next_state  = S_RUN;
               w_next_cnt    = '0;
            end else begin
               w_next_cnt = r_cnt + CNT_W'(1);
            end
         end

         default: begin
            // INIT (and the unused encoding, which recovers through INIT).
            w_stall_f = 1'b1;
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
            w_flush_w = 1'b1;
            if (r_state != S_INIT) begin
               w_next_state = S_INIT;
               w_next_cnt   = '0;
            end else if (r_cnt == INIT_LAST) begin
               w_next_state = S_RUN;
               w_next_cnt   = '0;
            end else begin
               w_next_cnt = r_cnt + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   assign hz.StallF     = w_stall_f;
   assign hz.StallD     = w_stall_d;
   assign hz.StallE     = w_stall_e;
   assign hz.StallM     = w_stall_m;
   assign hz.FlushD     = w_flush_d;
   assign hz.FlushE     = w_flush_e;
   assign hz.FlushW     = w_flush_w;
   assign hz.ForwardA_E = w_forward_a;
   assign hz.ForwardB_E = w_forward_b;
   assign hz.MemTimeout = w_mem_timeout;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural model (flush-window countdown + stall-cycle count per access).
module tb_hazard_sequencer;
   localparam int INIT_CYCLES = 4;
   localparam int MEM_TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard_sequencer_if u_if ();

   hazard_sequencer #(
      .INIT_CYCLES (INIT_CYCLES),
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (u_if)
   );

   int checks = 0;
   int errors = 0;

   // Model state: remaining flush-window cycles, and number of stall
   // cycles already spent on the current memory access (0 = none).
   int m_init_left = INIT_CYCLES;
   int m_waited    = 0;

   // DUT outputs as sampled in the most recent cycle.
   logic       s_stall_f, s_stall_d, s_stall_e, s_stall_m;
   logic       s_flush_d, s_flush_e, s_flush_w, s_timeout;
   logic [1:0] s_fa, s_fb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd(input logic [4:0] rs);
      if (u_if.RegWrite_M && u_if.Rd_M != 0 && u_if.Rd_M == rs) return 2'b10;
      if (u_if.RegWrite_W && u_if.Rd_W != 0 && u_if.Rd_W == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic idle();
      u_if.Rs1_D = 0; u_if.Rs2_D = 0; u_if.Rs1_E = 0; u_if.Rs2_E = 0;
      u_if.Rd_E = 0; u_if.Rd_M = 0; u_if.Rd_W = 0;
      u_if.RegWrite_M = 0; u_if.RegWrite_W = 0; u_if.ResultSrc_E = 0;
      u_if.PCSrc_E = 0; u_if.MemAccess_M = 0; u_if.DMemReady = 0;
   endtask

   // One clock: check at negedge against the model, advance model at posedge.
   task automatic cycle();
      logic lu, ms, stall, flushing;
      logic [9:0] e;   // {sf,sd,se,sm,fd,fe,fw,to} packed below
      logic [1:0] efa, efb;
      logic e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, e_to;
      @(negedge clk);
      lu = (u_if.ResultSrc_E == 2'b01) && (u_if.Rd_E != 0) &&
           (u_if.Rd_E == u_if.Rs1_D || u_if.Rd_E == u_if.Rs2_D);
      ms = u_if.MemAccess_M && !u_if.DMemReady;
      flushing = rst || (m_init_left > 0);
      stall = !flushing && (m_waited > 0 || ms);
      e = '0;
      if (flushing) begin
         e_sf = 1; e_sd = 0; e_se = 0; e_sm = 0; e_fd = 1; e_fe = 1; e_fw = 1; e_to = 0;
         efa = 0; efb = 0;
      end else if (stall) begin
         e_sf = 1; e_sd = 1; e_se = 1; e_sm = 1; e_fd = 0; e_fe = 0; e_fw = 1;
         e_to = (m_waited > 0) && !u_if.DMemReady && (m_waited + 1 == MEM_TIMEOUT);
         efa = fwd(u_if.Rs1_E); efb = fwd(u_if.Rs2_E);
      end else begin
         e_sf = lu; e_sd = lu; e_se = 0; e_sm = 0; e_fd = u_if.PCSrc_E;
         e_fe = lu | u_if.PCSrc_E; e_fw = 0; e_to = 0;
         efa = fwd(u_if.Rs1_E); efb = fwd(u_if.Rs2_E);
      end
      s_stall_f = u_if.StallF; s_stall_d = u_if.StallD;
      s_stall_e = u_if.StallE; s_stall_m = u_if.StallM;
      s_flush_d = u_if.FlushD; s_flush_e = u_if.FlushE;
      s_flush_w = u_if.FlushW; s_timeout = u_if.MemTimeout;
      s_fa = u_if.ForwardA_E; s_fb = u_if.ForwardB_E;
      chk("model_StallF", 32'(s_stall_f), 32'(e_sf));
      chk("model_StallD", 32'(s_stall_d), 32'(e_sd));
      chk("model_StallE", 32'(s_stall_e), 32'(e_se));
      chk("model_StallM", 32'(s_stall_m), 32'(e_sm));
      chk("model_FlushD", 32'(s_flush_d), 32'(e_fd));
      chk("model_FlushE", 32'(s_flush_e), 32'(e_fe));
      chk("model_FlushW", 32'(s_flush_w), 32'(e_fw));
      chk("model_MemTimeout", 32'(s_timeout), 32'(e_to));
      chk("model_ForwardA", 32'(s_fa), 32'(efa));
      chk("model_ForwardB", 32'(s_fb), 32'(efb));
      @(posedge clk);
      if (rst) begin
         m_init_left = INIT_CYCLES;
         m_waited = 0;
      end else if (m_init_left > 0) begin
         m_init_left--;
      end else if (m_waited > 0) begin
         if (u_if.DMemReady || m_waited + 1 == MEM_TIMEOUT) m_waited = 0;
         else m_waited++;
      end else if (ms) begin
         m_waited = 1;
      end
      #1;
   endtask

   initial begin
      int cnt, idx, hang;
      idle();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;

      // Post-reset flush window: exactly INIT_CYCLES cycles.
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (s_flush_d && s_flush_e && s_flush_w && s_stall_f) cnt++;
      end
      chk("init_window_len", cnt, 4);
      chk("run_StallF", 32'(s_stall_f), 0);
      chk("run_ForwardA", 32'(s_fa), 0);

      // Forwarding priority.
      u_if.Rd_M = 5; u_if.RegWrite_M = 1; u_if.Rd_W = 5; u_if.RegWrite_W = 1;
      u_if.Rs1_E = 5; u_if.Rs2_E = 0;
      cycle();
      chk("fwd_M_priority", 32'(s_fa), 32'h2);
      chk("fwd_x0_B", 32'(s_fb), 0);
      u_if.RegWrite_M = 0;
      cycle();
      chk("fwd_W", 32'(s_fa), 32'h1);
      idle();

      // Load-use.
      u_if.ResultSrc_E = 2'b01; u_if.Rd_E = 7; u_if.Rs2_D = 7;
      cycle();
      chk("lu_StallF", 32'(s_stall_f), 1);
      chk("lu_StallD", 32'(s_stall_d), 1);
      chk("lu_FlushE", 32'(s_flush_e), 1);
      chk("lu_FlushD", 32'(s_flush_d), 0);
      u_if.Rd_E = 0; u_if.Rs2_D = 0;
      cycle();
      chk("lu_x0_nostall", 32'(s_stall_f), 0);
      idle();

      // Memory stall: 3 not-ready cycles then ready.
      cnt = 0; idx = 0;
      u_if.MemAccess_M = 1;
      for (int i = 0; i < 4; i++) begin
         u_if.DMemReady = (i == 3);
         cycle();
         if (s_stall_f && s_stall_d && s_stall_e && s_stall_m && s_flush_w) cnt++;
         if (s_timeout) idx++;
      end
      idle();
      cycle();
      chk("mem_stall_cycles", cnt, 4);
      chk("mem_no_timeout", idx, 0);
      chk("mem_back_run", 32'(s_stall_m), 0);

      // Hung access: timeout in the 16th stall cycle.
      cnt = 0; idx = 0;
      u_if.MemAccess_M = 1; u_if.DMemReady = 0;
      for (int i = 1; i <= 20 && (idx == 0); i++) begin
         cycle();
         if (s_stall_m) cnt++;
         if (s_timeout) idx = i;
      end
      idle();
      cycle();
      chk("timeout_stall_cycles", cnt, 16);
      chk("timeout_pulse_idx", idx, 16);
      chk("timeout_back_run", 32'(s_stall_f), 0);

      // Branch held during a memory stall: flush deferred, not lost.
      u_if.MemAccess_M = 1; u_if.DMemReady = 0; u_if.PCSrc_E = 1;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         if (s_flush_d || s_flush_e) cnt++;
      end
      u_if.DMemReady = 1;
      cycle();
      if (s_flush_d || s_flush_e) cnt++;
      chk("br_flush_held_off", cnt, 0);
      u_if.MemAccess_M = 0;
      cycle();
      chk("br_FlushD_after", 32'(s_flush_d), 1);
      chk("br_FlushE_after", 32'(s_flush_e), 1);

      // Reset in the middle of MEMWAIT.
      u_if.PCSrc_E = 0; u_if.MemAccess_M = 1; u_if.DMemReady = 0;
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      chk("rst_StallF", 32'(s_stall_f), 1);
      chk("rst_StallD", 32'(s_stall_d), 0);
      chk("rst_StallE", 32'(s_stall_e), 0);
      chk("rst_StallM", 32'(s_stall_m), 0);
      rst = 1'b0;
      idle();

      // Randomized traffic; every third band of cycles holds memory hung.
      for (int i = 0; i < 3000; i++) begin
         hang = ((i / 300) % 3 == 2);
         u_if.Rs1_D = 5'($urandom_range(0, 3));
         u_if.Rs2_D = 5'($urandom_range(0, 3));
         u_if.Rs1_E = 5'($urandom_range(0, 3));
         u_if.Rs2_E = 5'($urandom_range(0, 3));
         u_if.Rd_E  = 5'($urandom_range(0, 3));
         u_if.Rd_M  = 5'($urandom_range(0, 3));
         u_if.Rd_W  = 5'($urandom_range(0, 3));
         u_if.RegWrite_M  = 1'($urandom_range(0, 1));
         u_if.RegWrite_W  = 1'($urandom_range(0, 1));
         u_if.ResultSrc_E = 2'($urandom_range(0, 3));
         u_if.PCSrc_E     = ($urandom_range(0, 3) == 0);
         u_if.MemAccess_M = ($urandom_range(0, 2) == 0);
         u_if.DMemReady   = hang ? ($urandom_range(0, 40) == 0) : ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 249) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
